// File: rtl/cde_pkg.sv
// Shared types for the credential datapath sequencer.
package cde_pkg;

  typedef enum logic [1:0] {
    OpBoot  = 2'd0,
    OpLogin = 2'd1,
    OpStore = 2'd2,
    OpRsvd  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    StatOk   = 2'd0,
    StatMiss = 2'd1,
    StatFull = 2'd2,
    StatErr  = 2'd3
  } status_e;

  typedef enum logic [3:0] {
    StIdle,
    StBootRd,
    StBootWr,
    StAccLoad,
    StStoreAcc,
    StCamStart,
    StCamWait,
    StLoginRd,
    StDecStart,
    StDecWait,
    StKey,
    StEncStart,
    StEncWait,
    StStoreWr,
    StStoreCam,
    StDone
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cde_if.sv
// Request/response and flash handshake bundle between a host and cde_ctrl.
interface cde_if #(
  parameter int unsigned ADDR_WIDTH = 4
) ();
  import cde_pkg::*;

  logic                req_valid;
  op_e                 req_op;
  logic [ADDR_WIDTH:0] boot_count;
  logic                req_ready;
  logic                resp_valid;
  status_e             resp_status;
  logic                flash_rd_req;
  logic                flash_rd_ack;
  logic                flash_wr_req;
  logic                flash_wr_ack;

  modport master (
    output req_valid, req_op, boot_count, flash_rd_ack, flash_wr_ack,
    input  req_ready, resp_valid, resp_status, flash_rd_req, flash_wr_req
  );

  modport slave (
    input  req_valid, req_op, boot_count, flash_rd_ack, flash_wr_ack,
    output req_ready, resp_valid, resp_status, flash_rd_req, flash_wr_req
  );

endinterface

// File: rtl/cde_wait_timer.sv
// Down-counter shared by the CAM latency wait and the handshake timeouts.
// expire is high while the count sits at zero.
module cde_wait_timer #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             count,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Load wins over counting; counting stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (count && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/cde_ctrl.sv
// Control sequencer for the credential datapath: BOOT / LOGIN / STORE requests,
// flash handshakes and CAM/AES latencies, one status per request.
module cde_ctrl
  import cde_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned CAM_LAT     = 2,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  cde_if.slave                  bus,
  input  logic                  match,
  input  logic                  dec_done,
  input  logic                  ready_encryption,
  output logic                  cam_start,
  output logic                  start_dec,
  output logic                  start_enc,
  output logic                  flash_pass_reg,
  output logic                  flash_acc_reg,
  output logic                  flash_or_acc_reg,
  output logic                  flash_or_acc_sel,
  output logic                  pass_enc_reg,
  output logic                  new_old_pass_sel,
  output logic                  plain_reg,
  output logic                  local_master_reg,
  output logic                  local_master_sel,
  output logic                  out_reg,
  output logic                  write_en,
  output logic                  boot_lood,
  output logic [ADDR_WIDTH-1:0] write_add
);

  localparam int unsigned Depth  = 2 ** ADDR_WIDTH;
  localparam int unsigned TimerW = $clog2(max_u(TIMEOUT_CYC, CAM_LAT) + 1);
  localparam logic [ADDR_WIDTH:0] DepthW  = (ADDR_WIDTH + 1)'(Depth);
  // Timer is loaded the cycle before a launch, so the launch cycle itself counts.
  localparam logic [TimerW-1:0]   ToLoad  = TimerW'(TIMEOUT_CYC - 1);
  localparam logic [TimerW-1:0]   CamLoad = TimerW'(CAM_LAT);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  status_e               status_q, status_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   boot_q, boot_d;
  logic [ADDR_WIDTH:0]   entry_q, entry_d;
  logic [ADDR_WIDTH:0]   addr_nxt;
  logic                  tmr_load, tmr_expire;
  logic [TimerW-1:0]     tmr_val;

  assign addr_nxt = {1'b0, addr_q} + 1'b1;

  cde_wait_timer #(
    .WIDTH (TimerW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .count    (state_q != StIdle),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // Next-state and all outputs; everything stays low while rst is high.
  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    status_d         = status_q;
    addr_d           = addr_q;
    boot_d           = boot_q;
    entry_d          = entry_q;
    tmr_load         = 1'b0;
    tmr_val          = ToLoad;
    bus.req_ready    = 1'b0;
    bus.resp_valid   = 1'b0;
    bus.resp_status  = StatOk;
    bus.flash_rd_req = 1'b0;
    bus.flash_wr_req = 1'b0;
    cam_start        = 1'b0;
    start_dec        = 1'b0;
    start_enc        = 1'b0;
    flash_pass_reg   = 1'b0;
    flash_acc_reg    = 1'b0;
    flash_or_acc_reg = 1'b0;
    flash_or_acc_sel = 1'b0;
    pass_enc_reg     = 1'b0;
    new_old_pass_sel = 1'b0;
    plain_reg        = 1'b0;
    local_master_reg = 1'b0;
    local_master_sel = 1'b0;
    out_reg          = 1'b0;
    write_en         = 1'b0;
    boot_lood        = 1'b0;
    write_add        = '0;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          bus.req_ready = 1'b1;
          if (bus.req_valid) begin
            op_d   = bus.req_op;
            addr_d = '0;
            unique case (bus.req_op)
              OpBoot: begin
                boot_d = (bus.boot_count > DepthW) ? DepthW : bus.boot_count;
                if (bus.boot_count == '0) begin
                  entry_d  = '0;
                  status_d = StatOk;
                  state_d  = StDone;
                end else begin
                  tmr_load = 1'b1;
                  state_d  = StBootRd;
                end
              end
              OpLogin: state_d = StAccLoad;
              OpStore: begin
                if (entry_q == DepthW) begin
                  status_d = StatFull;
                  state_d  = StDone;
                end else begin
                  state_d = StAccLoad;
                end
              end
              OpRsvd: begin
                status_d = StatErr;
                state_d  = StDone;
              end
            endcase
          end
        end
        StBootRd: begin
          write_add        = addr_q;
          bus.flash_rd_req = 1'b1;
          if (bus.flash_rd_ack) begin
            flash_or_acc_reg = 1'b1;
            state_d          = StBootWr;
          end else if (tmr_expire) begin
            status_d = StatErr;
            state_d  = StDone;
          end
        end
        StBootWr: begin
          write_en  = 1'b1;
          write_add = addr_q;
          if (addr_nxt == boot_q) begin
            entry_d  = boot_q;
            status_d = StatOk;
            state_d  = StDone;
          end else begin
            addr_d   = addr_nxt[ADDR_WIDTH-1:0];
            tmr_load = 1'b1;
            state_d  = StBootRd;
          end
        end
        StAccLoad: begin
          flash_or_acc_sel = 1'b1;
          flash_or_acc_reg = 1'b1;
          if (op_q == OpLogin) begin
            tmr_load = 1'b1;
            tmr_val  = CamLoad;
            state_d  = StCamStart;
          end else begin
            state_d = StStoreAcc;
          end
        end
        StStoreAcc: begin
          flash_acc_reg = 1'b1;
          state_d       = StKey;
        end
        StCamStart: begin
          cam_start = 1'b1;
          state_d   = StCamWait;
        end
        StCamWait: begin
          if (tmr_expire) begin
            if (match) begin
              tmr_load = 1'b1;
              state_d  = StLoginRd;
            end else begin
              status_d = StatMiss;
              state_d  = StDone;
            end
          end
        end
        StLoginRd: begin
          boot_lood        = 1'b1;
          bus.flash_rd_req = 1'b1;
          if (bus.flash_rd_ack) begin
            pass_enc_reg = 1'b1;
            tmr_load     = 1'b1;
            state_d      = StDecStart;
          end else if (tmr_expire) begin
            status_d = StatErr;
            state_d  = StDone;
          end
        end
        StDecStart: begin
          start_dec = 1'b1;
          state_d   = StDecWait;
        end
        StDecWait: begin
          if (dec_done) begin
            state_d = StKey;
          end else if (tmr_expire) begin
            status_d = StatErr;
            state_d  = StDone;
          end
        end
        StKey: begin
          // LOGIN re-encrypts the recovered password; STORE encrypts the new one.
          new_old_pass_sel = (op_q == OpLogin);
          plain_reg        = 1'b1;
          local_master_sel = (op_q == OpLogin);
          local_master_reg = 1'b1;
          tmr_load         = 1'b1;
          state_d          = StEncStart;
        end
        StEncStart: begin
          start_enc = 1'b1;
          state_d   = StEncWait;
        end
        StEncWait: begin
          if (ready_encryption) begin
            if (op_q == OpLogin) begin
              out_reg  = 1'b1;
              status_d = StatOk;
              state_d  = StDone;
            end else begin
              flash_pass_reg = 1'b1;
              tmr_load       = 1'b1;
              state_d        = StStoreWr;
            end
          end else if (tmr_expire) begin
            status_d = StatErr;
            state_d  = StDone;
          end
        end
        StStoreWr: begin
          write_add        = entry_q[ADDR_WIDTH-1:0];
          bus.flash_wr_req = 1'b1;
          if (bus.flash_wr_ack) begin
            state_d = StStoreCam;
          end else if (tmr_expire) begin
            status_d = StatErr;
            state_d  = StDone;
          end
        end
        StStoreCam: begin
          write_en  = 1'b1;
          write_add = entry_q[ADDR_WIDTH-1:0];
          if (entry_q != DepthW) begin
            entry_d = entry_q + 1'b1;
          end
          status_d = StatOk;
          state_d  = StDone;
        end
        StDone: begin
          bus.resp_valid  = 1'b1;
          bus.resp_status = status_q;
          state_d         = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OpBoot;
      status_q <= StatOk;
      addr_q   <= '0;
      boot_q   <= '0;
      entry_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      status_q <= status_d;
      addr_q   <= addr_d;
      boot_q   <= boot_d;
      entry_q  <= entry_d;
    end
  end

endmodule
